// File: rtl/approx_mult_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | approx_mult_pipe_if                                                      |
// | Operand/result valid-ready bundle for approx_mult_pipe.                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface approx_mult_pipe_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic [3:0]     in_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_prod;
  logic [3:0]     out_mode;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_prod, out_mode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_prod, out_mode
  );
endinterface
`default_nettype wire

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | approx_mult_pipe                                                         |
// | Quadrant-decomposed approximate multiplier, 3-stage elastic pipeline.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module approx_mult_pipe #(
  parameter int N     = 8,
  parameter int TRUNC = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  approx_mult_pipe_if.slave bus
);
  localparam int H = N / 2;

  // Keep-mask for approximate sub-products; one bit wider so TRUNC=N yields all zeros.
  localparam logic [N:0]   c_one  = (N+1)'(1);
  localparam logic [N:0]   c_low  = (c_one << TRUNC) - c_one;
  localparam logic [N-1:0] c_keep = ~c_low[N-1:0];

  logic           r_v1, r_v2, r_v3;
  logic [N-1:0]   r_a, r_b;
  logic [3:0]     r_mode1, r_mode2, r_mode3;
  logic [N-1:0]   r_sub [4];
  logic [2*N-1:0] r_prod;

  logic           w_rdy1, w_rdy2, w_rdy3;
  logic [N-1:0]   w_sub [4];
  logic [2*N-1:0] w_sum;

  // Each stage may load when its successor is empty or draining this cycle.
  assign w_rdy3 = !r_v3 || bus.out_ready;
  assign w_rdy2 = !r_v2 || w_rdy3;
  assign w_rdy1 = !r_v1 || w_rdy2;

  // Quadrant q: bit1 selects A half, bit0 selects B half (LL, LH, HL, HH).
  generate
    for (genvar q = 0; q < 4; q++) begin : g_quad
      localparam int c_a_lsb = (q / 2) * H;
      localparam int c_b_lsb = (q % 2) * H;
      logic [N-1:0] w_exact;
      assign w_exact  = N'(r_a[c_a_lsb +: H]) * N'(r_b[c_b_lsb +: H]);
      assign w_sub[q] = r_mode1[q] ? (w_exact & c_keep) : w_exact;
    end
  endgenerate

  always_comb begin
    w_sum = (2*N)'(r_sub[0])
          + ((2*N)'(r_sub[1]) << H)
          + ((2*N)'(r_sub[2]) << H)
          + ((2*N)'(r_sub[3]) << (2*H));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_mode1 <= '0;
      r_mode2 <= '0;
      r_mode3 <= '0;
      r_prod  <= '0;
      for (int i = 0; i < 4; i++) r_sub[i] <= '0;
    end else begin
      if (w_rdy1) begin
        r_v1 <= bus.in_valid;
        if (bus.in_valid) begin
          r_a     <= bus.in_a;
          r_b     <= bus.in_b;
          r_mode1 <= bus.in_mode;
        end
      end
      if (w_rdy2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          for (int i = 0; i < 4; i++) r_sub[i] <= w_sub[i];
          r_mode2 <= r_mode1;
        end
      end
      if (w_rdy3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_prod  <= w_sum;
          r_mode3 <= r_mode2;
        end
      end
    end
  end

  assign bus.in_ready  = w_rdy1;
  assign bus.out_valid = r_v3;
  assign bus.out_prod  = r_prod;
  assign bus.out_mode  = r_mode3;
endmodule
`default_nettype wire

// File: tb/tb_approx_mult_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_approx_mult_pipe                                                      |
// | Scoreboard bench for approx_mult_pipe (N=8/TRUNC=2 and N=16/TRUNC=0).    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_approx_mult_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_mult_pipe_if #(.N(8))  bus8 ();
  approx_mult_pipe_if #(.N(16)) bus16 ();

  approx_mult_pipe #(.N(8),  .TRUNC(2)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  approx_mult_pipe #(.N(16), .TRUNC(0)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  typedef struct {
    logic [31:0] prod;
    logic [3:0]  mode;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected none", name);
  endtask

  // Exact product minus the low bits dropped from each approximated quadrant.
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
    int exact, ll, lh, hl, hh;
    exact = int'(a) * int'(b);
    ll = int'(a[3:0]) * int'(b[3:0]);
    lh = int'(a[3:0]) * int'(b[7:4]);
    hl = int'(a[7:4]) * int'(b[3:0]);
    hh = int'(a[7:4]) * int'(b[7:4]);
    if (m[0]) exact -= (ll % 4);
    if (m[1]) exact -= (lh % 4) * 16;
    if (m[2]) exact -= (hl % 4) * 16;
    if (m[3]) exact -= (hh % 4) * 256;
    return 16'(exact);
  endfunction

  // Result monitor for the 8-bit instance, including hold-while-stalled checks.
  logic        stalled8 = 1'b0;
  logic [15:0] held_prod8;
  logic [3:0]  held_mode8;
  always @(negedge clk) begin
    if (rst) begin
      stalled8 = 1'b0;
    end else begin
      if (stalled8) begin
        check("hold_valid8", 32'(bus8.out_valid), 32'd1);
        check("hold_prod8", 32'(bus8.out_prod), 32'(held_prod8));
        check("hold_mode8", 32'(bus8.out_mode), 32'(held_mode8));
      end
      if (bus8.out_valid && bus8.out_ready) begin
        if (q8.size() == 0) begin
          fail_now("unexpected_out8");
        end else begin
          exp_t e;
          e = q8.pop_front();
          check("prod8", 32'(bus8.out_prod), e.prod);
          check("mode8", 32'(bus8.out_mode), 32'(e.mode));
        end
      end
      stalled8   = bus8.out_valid && !bus8.out_ready;
      held_prod8 = bus8.out_prod;
      held_mode8 = bus8.out_mode;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus16.out_valid && bus16.out_ready) begin
      if (q16.size() == 0) begin
        fail_now("unexpected_out16");
      end else begin
        exp_t e;
        e = q16.pop_front();
        check("prod16", bus16.out_prod, e.prod);
        check("mode16", 32'(bus16.out_mode), 32'(e.mode));
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m,
                       input logic [15:0] exp);
    int guard;
    guard = 0;
    bus8.in_valid = 1'b1;
    bus8.in_a     = a;
    bus8.in_b     = b;
    bus8.in_mode  = m;
    @(negedge clk);
    while (!bus8.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus8.in_ready) fail_now("accept_timeout8");
    else q8.push_back('{32'(exp), m});
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic drain8();
    int guard;
    guard = 0;
    while (q8.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (q8.size() != 0) fail_now("drain_timeout8");
    #1;
  endtask

  logic [7:0] sa [10] = '{8'h12, 8'hA5, 8'hFF, 8'h00, 8'h7E, 8'h39, 8'hC3, 8'h0F, 8'hF0, 8'h5D};
  logic [7:0] sb [10] = '{8'h34, 8'h5A, 8'h01, 8'h99, 8'h81, 8'hEE, 8'h3C, 8'hF0, 8'h0F, 8'hB7};
  logic [3:0] sm [10] = '{4'h0, 4'hF, 4'h5, 4'hA, 4'h3, 4'hC, 4'h9, 4'h6, 4'hF, 4'h1};

  initial begin
    int n;
    bus8.in_valid  = 1'b0;
    bus8.in_a      = '0;
    bus8.in_b      = '0;
    bus8.in_mode   = '0;
    bus8.out_ready = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_a      = '0;
    bus16.in_b      = '0;
    bus16.in_mode   = '0;
    bus16.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_out_prod", 32'(bus8.out_prod), 32'd0);
    check("rst_out_mode", 32'(bus8.out_mode), 32'd0);
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Exact full scale plus latency measurement.
    send8(8'hFF, 8'hFF, 4'b0000, 16'hFE01);
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd3);
    drain8();

    send8(8'hFF, 8'hFF, 4'b1111, 16'hFCE0);
    send8(8'h37, 8'h5A, 4'b0001, 16'h1354);
    send8(8'h37, 8'h5A, 4'b1000, 16'h1056);
    send8(8'h37, 8'h5A, 4'b0000, 16'h1356);
    drain8();

    // Back-to-back stream with a 6-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 10; i++) send8(sa[i], sb[i], sm[i], model8(sa[i], sb[i], sm[i]));
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus8.out_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("in_ready_full", 32'(bus8.in_ready), 32'd0);
        @(posedge clk);
        #1 bus8.out_ready = 1'b1;
        #1 check("in_ready_rise", 32'(bus8.in_ready), 32'd1);
      end
    join
    drain8();

    // Reset with two transactions in flight; neither may ever emerge.
    send8(8'h11, 8'h22, 4'b0000, 16'h0242);
    send8(8'h33, 8'h44, 4'b0000, 16'h0D8C);
    q8.delete();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("mid_rst_out_prod", 32'(bus8.out_prod), 32'd0);
    check("mid_rst_in_ready", 32'(bus8.in_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("flushed_quiet", 32'(bus8.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send8(8'h02, 8'h03, 4'b0000, 16'h0006);
    send8(8'h00, 8'hFF, 4'b0000, 16'h0000);
    send8(8'h00, 8'hFF, 4'b1111, 16'h0000);
    drain8();

    // 16-bit instance, TRUNC=0: mode has no effect.
    bus16.in_valid = 1'b1;
    bus16.in_a     = 16'hFFFF;
    bus16.in_b     = 16'hFFFF;
    bus16.in_mode  = 4'b1111;
    @(negedge clk);
    if (!bus16.in_ready) fail_now("accept16");
    else q16.push_back('{32'hFFFE0001, 4'b1111});
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    n = 0;
    while (q16.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (q16.size() != 0) fail_now("drain_timeout16");
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
